// File: rtl/sa_mux_pkg.sv
// Shared types and sizing helpers for the sequenced row multiplexer.
package sa_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // $clog2 returns 0 for n<=1, which cannot size a port; clamp to one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_row_n.sv
// Combinational N-way row select; indices outside the source range yield zero.
module mux_row_n
  import sa_mux_pkg::*;
#(
  parameter int ROW     = 9,
  parameter int NUM_SRC = 10,
  parameter int SEL_W   = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC*ROW-1:0] data,
  input  logic [SEL_W-1:0]       sel,
  output logic [ROW-1:0]         row
);

  always_comb begin
    row = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) row = data[k*ROW +: ROW];
    end
  end

endmodule

// File: rtl/mux_row_seq.sv
// Registered row multiplexer with direct and wrapping-sweep selection,
// feeding a single valid/ready output register that holds under backpressure.
module mux_row_seq
  import sa_mux_pkg::*;
#(
  parameter int ROW     = 9,
  parameter int NUM_SRC = 10,
  parameter int SEL_W   = clog2_min1(NUM_SRC),
  parameter int CNT_W   = clog2_min1(NUM_SRC) + 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_SRC*ROW-1:0] i_data,
  input  logic                   i_sel_valid,
  input  logic [SEL_W-1:0]       i_sel,
  output logic                   o_sel_ready,
  input  logic                   i_start,
  input  logic [SEL_W-1:0]       i_first,
  input  logic [CNT_W-1:0]       i_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ROW-1:0]         o_data,
  output logic [SEL_W-1:0]       o_src,
  output logic                   o_last
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] rem;
  logic             zero_done;

  logic             load;
  logic             start_go;
  logic             direct_go;
  logic             step_go;
  logic [SEL_W-1:0] mux_sel;
  logic [ROW-1:0]   mux_row;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] first_ok;

  assign load      = !o_valid || i_ready;
  assign start_go  = (state == IDLE) && i_start;
  assign direct_go = (state == IDLE) && !i_start && i_sel_valid && load;
  assign step_go   = (state == RUN) && load;

  assign o_sel_ready = (state == IDLE) && !i_start && load;
  assign o_busy      = (state == RUN);
  assign o_done      = zero_done || (o_valid && i_ready && o_last);

  assign mux_sel  = (state == RUN) ? ptr : i_sel;
  assign ptr_next = (ptr == SEL_W'(NUM_SRC - 1)) ? '0 : ptr + SEL_W'(1);
  assign first_ok = (int'(i_first) < NUM_SRC) ? i_first : '0;

  mux_row_n #(
    .ROW    (ROW),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .data(i_data),
    .sel (mux_sel),
    .row (mux_row)
  );

  // Sequencer and output register; i_data is sampled only when a beat loads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      zero_done <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_src     <= '0;
      o_last    <= 1'b0;
    end else begin
      zero_done <= start_go && (i_count == '0);
      if (start_go && (i_count != '0)) begin
        state <= RUN;
        ptr   <= first_ok;
        rem   <= i_count;
      end
      if (step_go) begin
        ptr <= ptr_next;
        rem <= rem - CNT_W'(1);
        if (rem == CNT_W'(1)) state <= IDLE;
      end
      if (load) begin
        o_valid <= direct_go || step_go;
        if (direct_go || step_go) begin
          o_data <= mux_row;
          o_src  <= mux_sel;
          o_last <= step_go && (rem == CNT_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_row_seq.sv
// Directed bench for mux_row_seq: direct, backpressure, sweep, zero-length, range and reset cases.
module tb_mux_row_seq;

  localparam int ROW     = 9;
  localparam int NUM_SRC = 10;
  localparam int SEL_W   = 4;
  localparam int CNT_W   = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_SRC*ROW-1:0] data;
  logic                   sel_valid;
  logic [SEL_W-1:0]       sel;
  logic                   sel_ready;
  logic                   start;
  logic [SEL_W-1:0]       first;
  logic [CNT_W-1:0]       count;
  logic                   busy;
  logic                   done;
  logic                   valid;
  logic                   ready;
  logic [ROW-1:0]         row;
  logic [SEL_W-1:0]       src;
  logic                   last;

  logic [ROW-1:0] src_val [NUM_SRC];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_SRC; k++) data[k*ROW +: ROW] = src_val[k];
  end

  mux_row_seq #(
    .ROW    (ROW),
    .NUM_SRC(NUM_SRC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data),
    .i_sel_valid(sel_valid),
    .i_sel      (sel),
    .o_sel_ready(sel_ready),
    .i_start    (start),
    .i_first    (first),
    .i_count    (count),
    .o_busy     (busy),
    .o_done     (done),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_data     (row),
    .o_src      (src),
    .o_last     (last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat observed at the current cycle: valid, data, index, last flag.
  task automatic check_beat(input string tag, input logic [ROW-1:0] d, input int s, input logic l);
    check({tag, ".valid"}, 32'(valid), 32'd1);
    check({tag, ".data"},  32'(row),   32'(d));
    check({tag, ".src"},   32'(src),   32'(s));
    check({tag, ".last"},  32'(last),  32'(l));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    src_val = '{9'h011, 9'h022, 9'h033, 9'h1A5, 9'h044,
                9'h055, 9'h066, 9'h077, 9'h188, 9'h199};
    rst = 1'b1; sel_valid = 1'b0; sel = '0; start = 1'b0;
    first = '0; count = '0; ready = 1'b1;
    tick(); tick();
    check("rst.valid", 32'(valid), 0);
    check("rst.data",  32'(row),   0);
    check("rst.src",   32'(src),   0);
    check("rst.last",  32'(last),  0);
    check("rst.busy",  32'(busy),  0);
    check("rst.done",  32'(done),  0);
    rst = 1'b0;

    // 1. direct select, downstream ready
    sel = 4'd3; sel_valid = 1'b1; #1;
    check("t1.sel_ready", 32'(sel_ready), 1);
    tick(); sel_valid = 1'b0;
    check_beat("t1.beat", 9'h1A5, 3, 1'b0);
    check("t1.done", 32'(done), 0);
    tick();
    check("t1.drain", 32'(valid), 0);

    // 2. backpressure holds the beat while the source changes
    ready = 1'b0; sel = 4'd2; sel_valid = 1'b1;
    tick(); sel_valid = 1'b0;
    check_beat("t2.load", 9'h033, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      src_val[2] = 9'(9'h0A0 + i);
      tick();
      check("t2.hold.data",  32'(row),       32'h033);
      check("t2.hold.valid", 32'(valid),     1);
      check("t2.sel_ready",  32'(sel_ready), 0);
    end
    src_val[2] = 9'h033;
    ready = 1'b1; #1;
    check("t2.release.ready", 32'(sel_ready), 1);
    tick();
    check("t2.released", 32'(valid), 0);

    // 3. sweep wraps 8,9,0,1
    start = 1'b1; first = 4'd8; count = 6'd4; #1;
    check("t3.collide.ready", 32'(sel_ready), 0);
    tick(); start = 1'b0;
    check("t3.busy0",  32'(busy),  1);
    check("t3.valid0", 32'(valid), 0);
    tick();
    check_beat("t3.b8", 9'h188, 8, 1'b0);
    check("t3.busy1", 32'(busy), 1);
    check("t3.done1", 32'(done), 0);
    tick();
    check_beat("t3.b9", 9'h199, 9, 1'b0);
    check("t3.busy2", 32'(busy), 1);
    tick();
    check_beat("t3.b0", 9'h011, 0, 1'b0);
    check("t3.busy3", 32'(busy), 1);
    tick();
    check_beat("t3.b1", 9'h022, 1, 1'b1);
    check("t3.busy4", 32'(busy), 0);
    check("t3.done",  32'(done), 1);
    tick();
    check("t3.after.valid", 32'(valid), 0);
    check("t3.after.done",  32'(done),  0);

    // 4. zero-length sweep
    start = 1'b1; first = 4'd5; count = 6'd0;
    tick(); start = 1'b0;
    check("t4.done",  32'(done),  1);
    check("t4.valid", 32'(valid), 0);
    check("t4.busy",  32'(busy),  0);
    tick();
    check("t4.done2",  32'(done),  0);
    check("t4.valid2", 32'(valid), 0);

    // 5a. out-of-range direct index
    sel = 4'd12; sel_valid = 1'b1;
    tick(); sel_valid = 1'b0;
    check_beat("t5.oor", 9'h000, 12, 1'b0);
    // 5b. start wins over a same-cycle direct request
    start = 1'b1; first = 4'd0; count = 6'd2; sel = 4'd5; sel_valid = 1'b1; #1;
    check("t5.collide.ready", 32'(sel_ready), 0);
    tick(); start = 1'b0; sel_valid = 1'b0;
    check("t5.no_direct", 32'(valid), 0);
    check("t5.busy",      32'(busy),  1);
    tick();
    check_beat("t5.b0", 9'h011, 0, 1'b0);
    tick();
    check_beat("t5.b1", 9'h022, 1, 1'b1);
    check("t5.done", 32'(done), 1);
    tick();

    // 6. asynchronous reset during beat 2 of a 5-beat sweep
    start = 1'b1; first = 4'd0; count = 6'd5;
    tick(); start = 1'b0;
    tick();
    check_beat("t6.b0", 9'h011, 0, 1'b0);
    tick();
    check_beat("t6.b1", 9'h022, 1, 1'b0);
    #2 rst = 1'b1; #1;
    check("t6.rst.valid", 32'(valid), 0);
    check("t6.rst.data",  32'(row),   0);
    check("t6.rst.src",   32'(src),   0);
    check("t6.rst.busy",  32'(busy),  0);
    check("t6.rst.done",  32'(done),  0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6.idle.valid", 32'(valid), 0);
    check("t6.idle.done",  32'(done),  0);
    start = 1'b1; first = 4'd3; count = 6'd2;
    tick(); start = 1'b0;
    check("t6.restart.busy", 32'(busy), 1);
    tick();
    check_beat("t6.r3", 9'h1A5, 3, 1'b0);
    tick();
    check_beat("t6.r4", 9'h044, 4, 1'b1);
    check("t6.r.done", 32'(done), 1);
    tick();
    check("t6.end.valid", 32'(valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
